// File: rtl/ps2_key_tracker.sv
// Game-key tracker: maps decoded PS/2 codes onto ten game keys, filters typematic
// repeats and queues key events in a FIFO. Build option: KEY_RELEASE_EVT_EN queues releases too.
module ps2_key_tracker #(
    parameter int FIFO_AW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       code_in,
    input  logic             code_rdy,
    output logic [9:0]       key_state,
    output logic             evt_valid,
    output logic [4:0]       evt_data,
    input  logic             evt_pop,
    output logic [FIFO_AW:0] evt_count,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    logic               hit;
    logic [3:0]         hit_idx;
    logic               is_break;
    logic               cur_held;
    logic               press;
    logic               release_key;
    logic               push_req;
    logic [4:0]         push_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               do_push;
    logic               do_pop;
    logic               drop;
    logic [9:0]         key_next;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [4:0]         mem [DEPTH];

    assign is_break = code_in[8];

    // The expand bit is part of the match, so keypad codes never alias the arrows.
    always_comb begin
        hit     = 1'b1;
        hit_idx = 4'd0;
        case ({code_in[9], code_in[7:0]})
            9'h01D:  hit_idx = 4'd0;
            9'h01C:  hit_idx = 4'd1;
            9'h01B:  hit_idx = 4'd2;
            9'h023:  hit_idx = 4'd3;
            9'h175:  hit_idx = 4'd4;
            9'h16B:  hit_idx = 4'd5;
            9'h172:  hit_idx = 4'd6;
            9'h174:  hit_idx = 4'd7;
            9'h029:  hit_idx = 4'd8;
            9'h05A:  hit_idx = 4'd9;
            default: hit     = 1'b0;
        endcase
    end

    assign cur_held    = key_state[hit_idx];
    assign press       = code_rdy && hit && !is_break && !cur_held;
    assign release_key = code_rdy && hit && is_break && cur_held;

    always_comb begin
        key_next = key_state;
        if (press)
            key_next[hit_idx] = 1'b1;
        else if (release_key)
            key_next[hit_idx] = 1'b0;
    end

`ifdef KEY_RELEASE_EVT_EN
    assign push_req  = press || release_key;
    assign push_data = {release_key, hit_idx};
`else
    assign push_req  = press;
    assign push_data = {1'b0, hit_idx};
`endif

    // Consumer handshake: the head entry is offered whenever evt_valid is high and is
    // consumed on any edge where evt_pop is also high; evt_pop with evt_valid low is ignored.
    assign fifo_full  = (evt_count == FULL_CNT);
    assign fifo_empty = (evt_count == '0);
    assign do_pop     = evt_pop && !fifo_empty;
    assign do_push    = push_req && (!fifo_full || do_pop);
    assign drop       = push_req && fifo_full && !do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            evt_count <= '0;
            ovf       <= 1'b0;
        end else begin
            key_state <= key_next;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   evt_count <= evt_count + 1'b1;
                2'b01:   evt_count <= evt_count - 1'b1;
                default: evt_count <= evt_count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Masking the head keeps evt_data at zero after reset without clearing storage.
    assign evt_valid = !fifo_empty;
    assign evt_data  = evt_valid ? mem[rd_ptr] : 5'd0;

endmodule
